stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised successor to the team's 4:1 combinational multiplexer.
- Selects one of NUM_CH DATA_W-bit valid/ready input channels and registers it onto a single output stream.
- Two selection modes: fixed (external select) or round-robin arbitration.
- Sits between several producer blocks and one shared consumer, for example a UART TX or LED/display driver.

Parameters:
- NUM_CH, 4: number of input channels (2..16).
- DATA_W, 8: data width per channel.
- SEL_W, $clog2(NUM_CH): select and channel-id width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready, combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  DATA_W  registered data.
- out_ch  output  SEL_W  registered index of the source channel.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1, so channel 0 has first priority.
- Transfer rules:
  - Input transfer on channel k when in_valid[k] && in_ready[k].
  - Output transfer when out_valid && out_ready.
- load_en = !out_valid || out_ready. A single output register drains and reloads in the same cycle, giving full throughput of 1 word/cycle.
- Latency: input accepted at edge N appears on out_data/out_valid after edge N.
- Grant (combinational, at most one-hot):
  - Fixed mode: grant[sel]=1 iff in_valid[sel] and sel < NUM_CH. An out-of-range sel gives no grant and all in_ready=0.
  - Round-robin mode: grant goes to the first channel with in_valid set, searching rr_ptr+1, rr_ptr+2, ... with wrap modulo NUM_CH. rr_ptr itself has lowest priority.
- in_ready[k] = load_en && grant[k]. No channel sees ready without a grant. in_ready must not depend on in_valid of the same channel beyond the grant logic.
- On an input transfer: out_data <= granted data; out_ch <= granted index; out_valid <= 1.
- In round-robin mode only, rr_ptr <= granted index on an input transfer.
- When load_en=1 and no grant: out_valid <= 0. out_data and out_ch hold their previous values.
- When load_en=0 (stalled): out_data, out_ch and out_valid all hold. Inputs are not acknowledged.
- Mode or sel changes take effect on the next arbitration cycle. A word already held in the output register is never altered or dropped.
- rr_ptr is not modified in fixed mode. Returning to round-robin resumes from the stored pointer.
- Mid-operation reset: the held word is discarded, out_valid drops immediately (async), and rr_ptr returns to NUM_CH-1.
- No combinational path from in_data to out_data.

Decomposition:
- Package stream_mux_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
  - A function for the wrap-around priority index.
- One sub-module: rr_arbiter.
  - Parameter NUM_CH.
  - Inputs: req, ptr, advance.
  - Outputs: grant (one-hot), grant_idx.
  - Owns rr_ptr and its reset.
  - stream_mux_rr wraps it with the fixed-mode override, handshake logic and output register.

Test Plan:
- Reset and idle: hold rst_n=0, then release with all in_valid=0. Require out_valid=0, out_data=0, out_ch=0, in_ready=4'b0000 on every cycle.
- Fixed mode single word: mode=0, sel=2, in_valid=4'b0100, ch2 data=8'hA5, out_ready=1. Require in_ready=4'b0100, then on the next cycle out_data=8'hA5, out_ch=2, out_valid=1.
- Round-robin fairness: mode=1, all four channels valid continuously with data 8'h10..8'h13, out_ready=1. Require out_ch sequence 0,1,2,3,0,1 and one word per cycle.
- Backpressure:
  - Stimulus: mode=1, in_valid=4'b1111, out_ready=0 for 3 cycles after the first word.
  - During the stall: in_ready=0, out_data held and unchanged, no input acknowledged.
  - After out_ready returns to 1: the next grant is the channel after the held out_ch.
- Out-of-range and mode switch:
  - NUM_CH=3 build with mode=0 and sel=3: require in_ready=0 and out_valid falls to 0.
  - Then switch to mode=1 mid-stream: the held word is preserved and arbitration resumes from the stored rr_ptr.
- Async reset mid-transfer: assert rst_n=0 between clock edges while out_valid=1. Require out_valid=0 immediately, and after release channel 0 wins first with in_valid=4'b1111.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
//   mode_e    : selection mode encoding (fixed select or round-robin)
//   wrap_idx  : wrap-around channel index used by the priority search
package stream_mux_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   // (base + offs) mod n, valid for base < n and offs <= n, which holds for
   // every call in the priority search; avoids a general modulo operator.
   function automatic int unsigned wrap_idx(input int unsigned base,
                                            input int unsigned offs,
                                            input int unsigned n);
      int unsigned s;
      s = base + offs;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a stored priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-channel request vector
//   ptr        : pointer value loaded when advance is high
//   advance    : load ptr into the stored pointer (on an accepted grant)
//   grant      : one-hot grant (all zero when no request)
//   grant_idx  : index of the granted channel (0 when no grant)
// The stored pointer marks the most recently served channel; the search
// starts one past it, so that channel has the lowest priority. It resets to
// NUM_CH-1 so channel 0 is served first.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int unsigned NUM_CH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH-1:0]         req,
   input  logic [$clog2(NUM_CH)-1:0] ptr,
   input  logic                      advance,
   output logic [NUM_CH-1:0]         grant,
   output logic [$clog2(NUM_CH)-1:0] grant_idx
);

   localparam int unsigned SEL_W = $clog2(NUM_CH);

   logic [SEL_W-1:0] rr_ptr;
   logic             found;
   int unsigned      cand;
   logic [SEL_W-1:0] cand_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= SEL_W'(NUM_CH - 1);
      end else if (advance) begin
         rr_ptr <= ptr;
      end
   end

   // Offsets 1..NUM_CH visit every channel once, ending on rr_ptr itself.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      cand_s    = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         cand   = wrap_idx(32'(rr_ptr), i, NUM_CH);
         cand_s = SEL_W'(cand);
         if (!found && req[cand_s]) begin
            found         = 1'b1;
            grant[cand_s] = 1'b1;
            grant_idx     = cand_s;
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : NUM_CH packed channels, channel k at [k*DATA_W +: DATA_W]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready (combinational, only for the granted one)
//   mode       : 0 = fixed select via sel, 1 = round-robin
//   sel        : channel index used in fixed mode (out of range = no grant)
//   out_data   : registered data word
//   out_ch     : registered source channel index
//   out_valid  : registered valid
//   out_ready  : consumer ready
// The single output register reloads whenever it is empty or draining, so
// the stream sustains one word per cycle.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   output logic                     out_valid,
   input  logic                     out_ready
);

   logic              rr_mode;
   logic              load_en;
   logic              any_grant;
   logic              xfer;
   logic              advance;
   logic [NUM_CH-1:0] arb_grant;
   logic [NUM_CH-1:0] fix_grant;
   logic [NUM_CH-1:0] grant;
   logic [SEL_W-1:0]  arb_idx;
   logic [SEL_W-1:0]  grant_idx;
   logic [DATA_W-1:0] grant_data;

   assign rr_mode = (mode_e'(mode) == MODE_RR);

   // The pointer only moves on an accepted round-robin grant; it is loaded
   // with the arbiter's own winner.
   rr_arbiter #(
      .NUM_CH(NUM_CH)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (in_valid),
      .ptr       (arb_idx),
      .advance   (advance),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   // Comparing sel against each index keeps an out-of-range sel from ever
   // indexing past the channel vector: it simply matches nothing.
   always_comb begin
      fix_grant = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (32'(sel) == k) begin
            fix_grant[k] = in_valid[k];
         end
      end
   end

   assign grant     = rr_mode ? arb_grant : fix_grant;
   assign grant_idx = rr_mode ? arb_idx : sel;
   assign any_grant = |grant;
   assign load_en   = !out_valid || out_ready;
   assign xfer      = load_en && any_grant;
   assign advance   = xfer && rr_mode;
   assign in_ready  = load_en ? grant : '0;

   // One-hot AND-OR mux of the granted channel's data.
   always_comb begin
      grant_data = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (grant[k]) begin
            grant_data = grant_data | in_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // An empty load cycle clears valid but keeps the last data/channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (load_en) begin
         if (any_grant) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant_idx;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance driven from a
// vector table, plus a 3-channel instance for the out-of-range select and
// mode-switch sequence, and a mid-transfer asynchronous reset.
module tb_stream_mux_rr;

   logic        clk;
   logic        rst_n;

   logic [31:0] a_in_data;
   logic [3:0]  a_in_valid;
   logic [3:0]  a_in_ready;
   logic        a_mode;
   logic [1:0]  a_sel;
   logic [7:0]  a_out_data;
   logic [1:0]  a_out_ch;
   logic        a_out_valid;
   logic        a_out_ready;

   logic [23:0] b_in_data;
   logic [2:0]  b_in_valid;
   logic [2:0]  b_in_ready;
   logic        b_mode;
   logic [1:0]  b_sel;
   logic [7:0]  b_out_data;
   logic [1:0]  b_out_ch;
   logic        b_out_valid;
   logic        b_out_ready;

   int n_cmp;
   int n_bad;

   stream_mux_rr #(
      .NUM_CH(4),
      .DATA_W(8)
   ) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (a_in_data),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .mode      (a_mode),
      .sel       (a_sel),
      .out_data  (a_out_data),
      .out_ch    (a_out_ch),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready)
   );

   stream_mux_rr #(
      .NUM_CH(3),
      .DATA_W(8)
   ) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (b_in_data),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .mode      (b_mode),
      .sel       (b_sel),
      .out_data  (b_out_data),
      .out_ch    (b_out_ch),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  valid;
      logic        mode;
      logic [1:0]  sel;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [7:0]  exp_od;
      logic [1:0]  exp_och;
   } vec_t;

   vec_t vt[23];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_a_out(input string tag, input logic ov, input logic [7:0] od,
                            input logic [1:0] och);
      chk({tag, ".out_valid"}, 32'(a_out_valid), 32'(ov));
      chk({tag, ".out_data"},  32'(a_out_data),  32'(od));
      chk({tag, ".out_ch"},    32'(a_out_ch),    32'(och));
   endtask

   // One cycle on the 3-channel instance: drive at negedge, check ready,
   // then check the registered outputs just after the rising edge.
   task automatic step_b(input string tag, input logic md, input logic [1:0] s,
                         input logic [2:0] v, input logic ordy, input logic [2:0] exp_rdy,
                         input logic ov, input logic [7:0] od, input logic [1:0] och);
      @(negedge clk);
      b_mode      = md;
      b_sel       = s;
      b_in_valid  = v;
      b_out_ready = ordy;
      #1;
      chk({tag, ".in_ready"}, 32'(b_in_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      chk({tag, ".out_valid"}, 32'(b_out_valid), 32'(ov));
      chk({tag, ".out_data"},  32'(b_out_data),  32'(od));
      chk({tag, ".out_ch"},    32'(b_out_ch),    32'(och));
   endtask

   localparam logic [31:0] D  = 32'h1312_1110;
   localparam logic [31:0] DA = 32'h13A5_1110;

   initial begin
      n_cmp = 0;
      n_bad = 0;

      //          data valid  mode  sel    ordy  rdy    ov    od     och
      vt[0]  = '{D,  4'h0, 1'b1, 2'd0, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0}; // idle
      vt[1]  = '{D,  4'h0, 1'b0, 2'd0, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0};
      vt[2]  = '{DA, 4'h4, 1'b0, 2'd2, 1'b1, 4'h4, 1'b1, 8'hA5, 2'd2}; // fixed sel 2
      vt[3]  = '{D,  4'h0, 1'b0, 2'd2, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd2}; // drain, hold data
      vt[4]  = '{D,  4'hF, 1'b1, 2'd0, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0}; // RR fairness
      vt[5]  = '{D,  4'hF, 1'b1, 2'd0, 1'b1, 4'h2, 1'b1, 8'h11, 2'd1};
      vt[6]  = '{D,  4'hF, 1'b1, 2'd0, 1'b1, 4'h4, 1'b1, 8'h12, 2'd2};
      vt[7]  = '{D,  4'hF, 1'b1, 2'd0, 1'b1, 4'h8, 1'b1, 8'h13, 2'd3};
      vt[8]  = '{D,  4'hF, 1'b1, 2'd0, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0};
      vt[9]  = '{D,  4'hF, 1'b1, 2'd0, 1'b1, 4'h2, 1'b1, 8'h11, 2'd1};
      vt[10] = '{D,  4'hF, 1'b1, 2'd0, 1'b0, 4'h0, 1'b1, 8'h11, 2'd1}; // stall x3
      vt[11] = '{D,  4'hF, 1'b1, 2'd0, 1'b0, 4'h0, 1'b1, 8'h11, 2'd1};
      vt[12] = '{D,  4'hF, 1'b1, 2'd0, 1'b0, 4'h0, 1'b1, 8'h11, 2'd1};
      vt[13] = '{D,  4'hF, 1'b1, 2'd0, 1'b1, 4'h4, 1'b1, 8'h12, 2'd2}; // resume after ch1
      vt[14] = '{D,  4'hF, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0}; // fixed, ptr kept
      vt[15] = '{D,  4'hF, 1'b1, 2'd0, 1'b1, 4'h8, 1'b1, 8'h13, 2'd3}; // RR from ptr 2
      vt[16] = '{D,  4'h5, 1'b1, 2'd0, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0}; // sparse requests
      vt[17] = '{D,  4'h5, 1'b1, 2'd0, 1'b1, 4'h4, 1'b1, 8'h12, 2'd2};
      vt[18] = '{D,  4'h1, 1'b1, 2'd0, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0}; // wrap to ch0
      vt[19] = '{D,  4'hD, 1'b0, 2'd1, 1'b1, 4'h0, 1'b0, 8'h10, 2'd0}; // sel on idle ch
      vt[20] = '{D,  4'h2, 1'b1, 2'd0, 1'b0, 4'h2, 1'b1, 8'h11, 2'd1}; // empty reg loads
      vt[21] = '{D,  4'hF, 1'b1, 2'd0, 1'b0, 4'h0, 1'b1, 8'h11, 2'd1}; // full reg stalls
      vt[22] = '{D,  4'h0, 1'b1, 2'd0, 1'b1, 4'h0, 1'b0, 8'h11, 2'd1};

      rst_n       = 1'b0;
      a_in_data   = D;
      a_in_valid  = '0;
      a_mode      = 1'b0;
      a_sel       = '0;
      a_out_ready = 1'b1;
      b_in_data   = 24'hB2_B1_B0;
      b_in_valid  = '0;
      b_mode      = 1'b0;
      b_sel       = '0;
      b_out_ready = 1'b1;

      // Reset held: outputs cleared, no channel acknowledged.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_a_out($sformatf("rst%0d", i), 1'b0, 8'h00, 2'd0);
         chk($sformatf("rst%0d.in_ready", i), 32'(a_in_ready), 32'h0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         a_in_data   = vt[i].data;
         a_in_valid  = vt[i].valid;
         a_mode      = vt[i].mode;
         a_sel       = vt[i].sel;
         a_out_ready = vt[i].ordy;
         #1;
         chk($sformatf("v%0d.in_ready", i), 32'(a_in_ready), 32'(vt[i].exp_rdy));
         @(posedge clk);
         #1;
         chk_a_out($sformatf("v%0d", i), vt[i].exp_ov, vt[i].exp_od, vt[i].exp_och);
      end

      // Mid-transfer async reset: pointer is at 1, so ch2 loads and stalls.
      @(negedge clk);
      a_in_data   = D;
      a_in_valid  = 4'hF;
      a_mode      = 1'b1;
      a_out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk_a_out("prerst", 1'b1, 8'h12, 2'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_a_out("asyncrst", 1'b0, 8'h00, 2'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n       = 1'b1;
      a_out_ready = 1'b1;
      #1;
      chk("postrst.in_ready", 32'(a_in_ready), 32'h1);
      @(posedge clk);
      #1;
      chk_a_out("postrst", 1'b1, 8'h10, 2'd0);

      // 3-channel build: out-of-range select, then mode switches around a held word.
      step_b("b1", 1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 8'hB0, 2'd0);
      step_b("b2", 1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 8'hB0, 2'd0);
      step_b("b3", 1'b1, 2'd3, 3'b111, 1'b0, 3'b010, 1'b1, 8'hB1, 2'd1);
      step_b("b4", 1'b0, 2'd3, 3'b111, 1'b0, 3'b000, 1'b1, 8'hB1, 2'd1);
      step_b("b5", 1'b1, 2'd3, 3'b111, 1'b0, 3'b000, 1'b1, 8'hB1, 2'd1);
      step_b("b6", 1'b1, 2'd3, 3'b111, 1'b1, 3'b100, 1'b1, 8'hB2, 2'd2);
      step_b("b7", 1'b1, 2'd3, 3'b111, 1'b1, 3'b001, 1'b1, 8'hB0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
